// File: rtl/mult_unit_pkg.sv
// Shared definitions for the iterative HI/LO multiplier: FSM state encoding and default geometry.
package mult_unit_pkg;

    localparam int unsigned MULT_WIDTH_DEF = 32;
    localparam int unsigned MULT_RADIX_DEF = 1;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_CALC = 2'd1,
        MS_FIX  = 2'd2
    } mult_state_e;

endpackage

// File: rtl/mult_unit_if.sv
// Decoder/WB-side bundle of the multiplier: start request, operands, flush, HI/LO and status.
interface mult_unit_if import mult_unit_pkg::*; #(
    parameter int unsigned WIDTH = MULT_WIDTH_DEF
) ();

    logic             MultStart;
    logic             MultSgn;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             Flush;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic             Busy;
    logic             Done;

    modport master (
        output MultStart, MultSgn, SrcA, SrcB, Flush,
        input  Hi, Lo, Busy, Done
    );

    modport slave (
        input  MultStart, MultSgn, SrcA, SrcB, Flush,
        output Hi, Lo, Busy, Done
    );

endinterface

// File: rtl/mult_unit_step.sv
// One CALC iteration: partial product of RADIX_BITS multiplier bits, shifted into the accumulator.
module mult_unit_step import mult_unit_pkg::*; #(
    parameter int unsigned WIDTH      = MULT_WIDTH_DEF,
    parameter int unsigned RADIX_BITS = MULT_RADIX_DEF,
    localparam int unsigned ACC_W     = 2*WIDTH + RADIX_BITS,
    localparam int unsigned SH_W      = $clog2(2*WIDTH)
) (
    input  logic [WIDTH-1:0]      i_mcand,
    input  logic [RADIX_BITS-1:0] i_bits,
    input  logic [SH_W-1:0]       i_shamt,
    input  logic [ACC_W-1:0]      i_acc,
    output logic [ACC_W-1:0]      o_acc_c
);

    localparam int unsigned PP_W = WIDTH + RADIX_BITS;

    logic [PP_W-1:0] w_pp;

    assign w_pp    = PP_W'(i_mcand) * PP_W'(i_bits);
    assign o_acc_c = i_acc + (ACC_W'(w_pp) << i_shamt);

endmodule

// File: rtl/mult_unit.sv
// Iterative mult/multu unit: magnitude shift-add over N=WIDTH/RADIX_BITS cycles, then sign fix-up into HI/LO.
module mult_unit import mult_unit_pkg::*; #(
    parameter int unsigned WIDTH      = MULT_WIDTH_DEF,
    parameter int unsigned RADIX_BITS = MULT_RADIX_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    mult_unit_if.slave io_bus
);

    localparam int unsigned N     = WIDTH / RADIX_BITS;
    localparam int unsigned CNT_W = $clog2(N + 1);
    localparam int unsigned ACC_W = 2*WIDTH + RADIX_BITS;
    localparam int unsigned SH_W  = $clog2(2*WIDTH);

    mult_state_e          r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [SH_W-1:0]      r_shamt;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic                 r_neg;
    logic [ACC_W-1:0]     r_acc;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_busy;
    logic                 r_done;

    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic                 w_neg;
    logic [ACC_W-1:0]     w_acc_next;
    logic [2*WIDTH-1:0]   w_mag;
    logic [2*WIDTH-1:0]   w_res;
    logic                 w_unused_carry;

    // Magnitudes stay unsigned: |0x80..0| is the same bit pattern read as 2^(WIDTH-1).
    assign w_abs_a = (io_bus.MultSgn && io_bus.SrcA[WIDTH-1]) ? -io_bus.SrcA : io_bus.SrcA;
    assign w_abs_b = (io_bus.MultSgn && io_bus.SrcB[WIDTH-1]) ? -io_bus.SrcB : io_bus.SrcB;
    assign w_neg   = io_bus.MultSgn && (io_bus.SrcA[WIDTH-1] ^ io_bus.SrcB[WIDTH-1]);

    mult_unit_step #(
        .WIDTH      (WIDTH),
        .RADIX_BITS (RADIX_BITS)
    ) u_step (
        .i_mcand (r_mcand),
        .i_bits  (r_mplier[RADIX_BITS-1:0]),
        .i_shamt (r_shamt),
        .i_acc   (r_acc),
        .o_acc_c (w_acc_next)
    );

    // The product of two WIDTH-bit magnitudes never reaches the carry bits.
    assign w_mag          = r_acc[2*WIDTH-1:0];
    assign w_res          = r_neg ? -w_mag : w_mag;
    assign w_unused_carry = ^r_acc[ACC_W-1:2*WIDTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= MS_IDLE;
            r_cnt    <= '0;
            r_shamt  <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                MS_IDLE: begin
                    if (io_bus.MultStart && !io_bus.Flush) begin
                        r_mcand  <= w_abs_a;
                        r_mplier <= w_abs_b;
                        r_neg    <= w_neg;
                        r_acc    <= '0;
                        r_cnt    <= CNT_W'(N);
                        r_shamt  <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= MS_CALC;
                    end
                end
                MS_CALC: begin
                    if (io_bus.Flush) begin
                        r_busy  <= 1'b0;
                        r_state <= MS_IDLE;
                    end else begin
                        r_acc    <= w_acc_next;
                        r_mplier <= r_mplier >> RADIX_BITS;
                        r_cnt    <= r_cnt - CNT_W'(1);
                        r_shamt  <= r_shamt + SH_W'(RADIX_BITS);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= MS_FIX;
                        end
                    end
                end
                MS_FIX: begin
                    if (!io_bus.Flush) begin
                        r_hi   <= w_res[2*WIDTH-1:WIDTH];
                        r_lo   <= w_res[WIDTH-1:0];
                        r_done <= 1'b1;
                    end
                    r_busy  <= 1'b0;
                    r_state <= MS_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= MS_IDLE;
                end
            endcase
        end
    end

    assign io_bus.Hi   = r_hi;
    assign io_bus.Lo   = r_lo;
    assign io_bus.Busy = r_busy;
    assign io_bus.Done = r_done;

endmodule

// File: tb/tb_mult_unit.sv
// Randomized self-checking bench for mult_unit at RADIX_BITS=1 and RADIX_BITS=4 against a 64-bit arithmetic model.
module tb_mult_unit;

    localparam int unsigned W = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        start;
    logic        sgn;
    logic        flush;
    logic [31:0] src_a;
    logic [31:0] src_b;

    logic [31:0] o_hi;
    logic [31:0] o_lo;
    logic        o_busy;
    logic        o_done;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] last_hilo [0:1];

    always #5 clk = ~clk;

    mult_unit_if #(.WIDTH(W)) bus1 ();
    mult_unit_if #(.WIDTH(W)) bus4 ();

    assign bus1.MultStart = start & ~sel;
    assign bus1.MultSgn   = sgn;
    assign bus1.SrcA      = src_a;
    assign bus1.SrcB      = src_b;
    assign bus1.Flush     = flush & ~sel;
    assign bus4.MultStart = start & sel;
    assign bus4.MultSgn   = sgn;
    assign bus4.SrcA      = src_a;
    assign bus4.SrcB      = src_b;
    assign bus4.Flush     = flush & sel;

    assign o_hi   = sel ? bus4.Hi   : bus1.Hi;
    assign o_lo   = sel ? bus4.Lo   : bus1.Lo;
    assign o_busy = sel ? bus4.Busy : bus1.Busy;
    assign o_done = sel ? bus4.Done : bus1.Done;

    mult_unit #(.WIDTH(W), .RADIX_BITS(1)) u_dut1 (
        .clk     (clk),
        .reset_n (rst_n),
        .io_bus  (bus1)
    );

    mult_unit #(.WIDTH(W), .RADIX_BITS(4)) u_dut4 (
        .clk     (clk),
        .reset_n (rst_n),
        .io_bus  (bus4)
    );

    // Reference: extend to 64 bits per signedness; the low 64 bits of the product are exact.
    function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = s ? {{32{a[31]}}, a} : {32'h0, a};
        eb = s ? {{32{b[31]}}, b} : {32'h0, b};
        return ea * eb;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (sel=%0d t=%0t)", tag, obs, exp, sel, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int nsteps();
        return sel ? 8 : 32;
    endfunction

    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
        start = 1'b1;
        src_a = a;
        src_b = b;
        sgn   = s;
    endtask

    // Called with a start already driven; the next edge is E0. Optionally pulses a stray start at E(poke).
    task automatic wait_done(input string tag, input logic [63:0] exp, input int poke);
        int k;
        int n;
        n = nsteps();
        tick();
        start = 1'b0;
        src_a = $urandom;
        src_b = $urandom;
        sgn   = 1'($urandom);
        check({tag, " busy"}, 64'(o_busy), 64'd1);
        k = 0;
        while (!o_done && k < 300) begin
            tick();
            k++;
            start = 1'b0;
            if (poke != 0 && k == poke) begin
                launch($urandom, $urandom, 1'($urandom));
            end
            if (k == n / 2) begin
                check({tag, " hold"}, {o_hi, o_lo}, last_hilo[sel]);
            end
        end
        start = 1'b0;
        check({tag, " latency"}, 64'(k), 64'(n + 1));
        check({tag, " result"}, {o_hi, o_lo}, exp);
        check({tag, " idle"}, 64'(o_busy), 64'd0);
        last_hilo[sel] = exp;
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s, input string tag, input int poke);
        launch(a, b, s);
        wait_done(tag, ref_product(a, b, s), poke);
        tick();
        check({tag, " pulse"}, 64'(o_done), 64'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] corners [0:4];
        int          idx;
        corners[0] = 32'h0;
        corners[1] = 32'h1;
        corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'h7FFF_FFFF;
        idx = int'($urandom_range(0, 7));
        return (idx < 5) ? corners[idx] : $urandom;
    endfunction

    initial begin
        int ndone;
        rst_n = 1'b0;
        sel   = 1'b0;
        start = 1'b0;
        sgn   = 1'b0;
        flush = 1'b0;
        src_a = '0;
        src_b = '0;
        last_hilo[0] = '0;
        last_hilo[1] = '0;
        repeat (3) tick();
        for (int u = 0; u < 2; u++) begin
            sel = 1'(u);
            #1;
            check("reset hilo", {o_hi, o_lo}, 64'h0);
            check("reset busy", 64'(o_busy), 64'd0);
            check("reset done", 64'(o_done), 64'd0);
        end
        sel = 1'b0;
        #2 rst_n = 1'b1;
        tick();

        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu max", 0);
        do_op(32'hFFFF_FFFD, 32'h0000_0007, 1'b1, "mult -3*7", 0);
        do_op(32'h8000_0000, 32'h8000_0000, 1'b1, "mult min*min", 0);
        do_op(32'h8000_0000, 32'h0000_0001, 1'b1, "mult min*1", 0);
        do_op(32'h0000_0005, 32'h0000_0006, 1'b0, "stray start", 10);

        // Flush mid-CALC with a stray start at E10: no write, no Done.
        do_op(32'h0000_0012, 32'h0000_0034, 1'b0, "preload", 0);
        launch(32'd5, 32'd6, 1'b0);
        tick();
        start = 1'b0;
        repeat (9) tick();
        launch(32'd7, 32'd9, 1'b0);
        tick();
        start = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush busy", 64'(o_busy), 64'd0);
        ndone = 0;
        repeat (40) begin
            tick();
            if (o_done) ndone++;
        end
        check("flush no done", 64'(ndone), 64'd0);
        check("flush hilo", {o_hi, o_lo}, last_hilo[0]);

        // Flush and start together in IDLE: flush wins.
        launch(32'd3, 32'd3, 1'b0);
        flush = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        check("flush+start busy", 64'(o_busy), 64'd0);

        // Async reset between edges in the middle of CALC.
        launch($urandom, $urandom, 1'b0);
        tick();
        start = 1'b0;
        repeat (10) tick();
        #3 rst_n = 1'b0;
        #1;
        check("async rst hilo", {o_hi, o_lo}, 64'h0);
        check("async rst busy", 64'(o_busy), 64'd0);
        last_hilo[0] = '0;
        last_hilo[1] = '0;
        #2 rst_n = 1'b1;
        tick();
        do_op(32'd2, 32'd3, 1'b0, "after rst", 0);

        for (int u = 0; u < 2; u++) begin
            sel = 1'(u);
            #1;
            // Flush in FIX cycle: result discarded.
            launch(32'd11, 32'd13, 1'b0);
            tick();
            start = 1'b0;
            repeat (nsteps()) tick();
            flush = 1'b1;
            tick();
            flush = 1'b0;
            check("flush fix done", 64'(o_done), 64'd0);
            check("flush fix hilo", {o_hi, o_lo}, last_hilo[sel]);
            tick();

            // Back-to-back: second start driven during the Done cycle.
            launch(32'd2, 32'd3, 1'b0);
            wait_done("b2b first", 64'd6, 0);
            launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
            wait_done("b2b second", 64'd1, 0);
            tick();
            check("b2b pulse", 64'(o_done), 64'd0);

            for (int i = 0; i < 25; i++) begin
                int poke;
                poke = (($urandom & 3) == 0) ? int'($urandom_range(1, nsteps() - 1)) : 0;
                do_op(pick_operand(), pick_operand(), 1'($urandom), "random", poke);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
